// File: rtl/cdb_arbiter.sv
// Round-robin completion arbiter: grants one done functional unit per cycle, returns a one-hot ack
// and drives the registered Common Data Bus broadcast.
module cdb_arbiter #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned XLEN   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [NUM_FU-1:0]       fu_done,
  input  logic [NUM_FU*XLEN-1:0]  fu_v,
  input  logic [NUM_FU*TAG_W-1:0] fu_rob_tag,
  input  logic [NUM_FU-1:0]       fu_take_branch,
  input  logic [NUM_FU*XLEN-1:0]  fu_branch_loc,
  output logic [NUM_FU-1:0]       ack,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_rob_tag,
  output logic [XLEN-1:0]         cdb_v,
  output logic                    cdb_take_branch,
  output logic [XLEN-1:0]         cdb_branch_loc
);

  localparam int unsigned PtrW = $clog2(NUM_FU);

  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  winner;
  logic             found;
  logic             grant;

  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_rob_tag_q, cdb_rob_tag_d;
  logic [XLEN-1:0]  cdb_v_q, cdb_v_d;
  logic             cdb_take_branch_q, cdb_take_branch_d;
  logic [XLEN-1:0]  cdb_branch_loc_q, cdb_branch_loc_d;

  // Scan from ptr upward with wrap; the first done unit wins.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      idx = (32'(ptr_q) + k) % NUM_FU;
      if (!found && fu_done[idx[PtrW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PtrW-1:0];
      end
    end
  end

  // Squash and reset both suppress the grant so no FU packet is dropped without broadcast.
  assign grant = found && !reset && !squash;

  always_comb begin
    ack = '0;
    if (grant) begin
      ack[winner] = 1'b1;
    end
  end

  always_comb begin
    ptr_d             = ptr_q;
    cdb_valid_d       = grant;
    cdb_rob_tag_d     = '0;
    cdb_v_d           = '0;
    cdb_take_branch_d = 1'b0;
    cdb_branch_loc_d  = '0;
    if (reset || squash) begin
      ptr_d = '0;
    end else if (grant) begin
      ptr_d             = (winner == PtrW'(NUM_FU - 1)) ? '0 : winner + 1'b1;
      cdb_rob_tag_d     = fu_rob_tag[32'(winner) * TAG_W +: TAG_W];
      cdb_v_d           = fu_v[32'(winner) * XLEN +: XLEN];
      cdb_take_branch_d = fu_take_branch[winner];
      cdb_branch_loc_d  = fu_branch_loc[32'(winner) * XLEN +: XLEN];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q             <= '0;
      cdb_valid_q       <= 1'b0;
      cdb_rob_tag_q     <= '0;
      cdb_v_q           <= '0;
      cdb_take_branch_q <= 1'b0;
      cdb_branch_loc_q  <= '0;
    end else begin
      ptr_q             <= ptr_d;
      cdb_valid_q       <= cdb_valid_d;
      cdb_rob_tag_q     <= cdb_rob_tag_d;
      cdb_v_q           <= cdb_v_d;
      cdb_take_branch_q <= cdb_take_branch_d;
      cdb_branch_loc_q  <= cdb_branch_loc_d;
    end
  end

  assign cdb_valid       = cdb_valid_q;
  assign cdb_rob_tag     = cdb_rob_tag_q;
  assign cdb_v           = cdb_v_q;
  assign cdb_take_branch = cdb_take_branch_q;
  assign cdb_branch_loc  = cdb_branch_loc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: hand-derived ack table plus a random phase against a round-robin model;
// expected CDB contents are queued when a cycle is driven and compared on the following cycle.
module tb_cdb_arbiter;

  localparam int unsigned NFU = 4;
  localparam int unsigned TW  = 5;
  localparam int unsigned XL  = 32;

  typedef struct packed {
    logic [NFU-1:0] done;
    logic           sq;
    logic           rst;
    logic [NFU-1:0] ack;
  } vec_t;

  typedef logic [1+TW+XL+1+XL-1:0] cdb_t;

  logic              clock = 1'b0;
  logic              reset, squash;
  logic [NFU-1:0]    fu_done, fu_take_branch, ack;
  logic [NFU*XL-1:0] fu_v, fu_branch_loc;
  logic [NFU*TW-1:0] fu_rob_tag;
  logic              cdb_valid, cdb_take_branch;
  logic [TW-1:0]     cdb_rob_tag;
  logic [XL-1:0]     cdb_v, cdb_branch_loc;

  logic [XL-1:0] d_v [NFU];
  logic [TW-1:0] d_tag [NFU];
  logic          d_tb [NFU];
  logic [XL-1:0] d_bl [NFU];

  cdb_t        exp_q[$];
  vec_t        tbl [26];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned step_no  = 0;
  int unsigned m_ptr    = 0;

  cdb_arbiter #(.NUM_FU(NFU), .TAG_W(TW), .XLEN(XL)) dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .fu_done        (fu_done),
    .fu_v           (fu_v),
    .fu_rob_tag     (fu_rob_tag),
    .fu_take_branch (fu_take_branch),
    .fu_branch_loc  (fu_branch_loc),
    .ack            (ack),
    .cdb_valid      (cdb_valid),
    .cdb_rob_tag    (cdb_rob_tag),
    .cdb_v          (cdb_v),
    .cdb_take_branch(cdb_take_branch),
    .cdb_branch_loc (cdb_branch_loc)
  );

  always #5 clock = ~clock;

  function automatic int unsigned onehot_idx(input logic [NFU-1:0] oh);
    int unsigned r = 0;
    for (int unsigned i = 0; i < NFU; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // Reference round-robin: walk offsets from the model pointer.
  function automatic logic [NFU-1:0] model_ack(input logic [NFU-1:0] done, input logic sq,
                                               input logic rst);
    int unsigned off = 0;
    if (rst || sq) return '0;
    while (off < NFU) begin
      if (done[(m_ptr + off) % NFU]) return NFU'(1) << ((m_ptr + off) % NFU);
      off++;
    end
    return '0;
  endfunction

  // Called one time unit after a posedge; returns one time unit after the next posedge.
  task automatic step(input logic [NFU-1:0] done, input logic sq, input logic rst,
                      input logic [NFU-1:0] exp_ack);
    cdb_t got, expv;
    int unsigned w;
    reset   = rst;
    squash  = sq;
    fu_done = done;
    for (int unsigned i = 0; i < NFU; i++) begin
      fu_v[i*XL +: XL]          = d_v[i];
      fu_rob_tag[i*TW +: TW]    = d_tag[i];
      fu_take_branch[i]         = d_tb[i];
      fu_branch_loc[i*XL +: XL] = d_bl[i];
    end
    #4;
    n_checks++;
    if (ack === exp_ack) n_pass++;
    else $display("FAIL ack step %0d: got %b required %b", step_no, ack, exp_ack);
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      got  = {cdb_valid, cdb_rob_tag, cdb_v, cdb_take_branch, cdb_branch_loc};
      n_checks++;
      if (got === expv) n_pass++;
      else $display("FAIL cdb step %0d: got %h required %h", step_no, got, expv);
    end
    if (exp_ack == '0) begin
      exp_q.push_back('0);
    end else begin
      w = onehot_idx(exp_ack);
      exp_q.push_back({1'b1, d_tag[w], d_v[w], d_tb[w], d_bl[w]});
    end
    step_no++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [NFU-1:0] rd, ra;
    logic           rs;
    d_v   = '{32'h1111_0000, 32'h0000_00AA, 32'h2222_2222, 32'h3333_3333};
    d_tag = '{5'd3, 5'd7, 5'd12, 5'd25};
    d_tb  = '{1'b1, 1'b0, 1'b1, 1'b0};
    d_bl  = '{32'h0000_1040, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000};

    // {done, squash, reset, expected ack}
    tbl[0]  = '{4'b0000, 1'b0, 1'b1, 4'b0000};
    tbl[1]  = '{4'b1111, 1'b0, 1'b1, 4'b0000};
    tbl[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[3]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[5]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[7]  = '{4'b0010, 1'b0, 1'b0, 4'b0010};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0100, 1'b1, 1'b0, 4'b0000};
    tbl[10] = '{4'b0100, 1'b0, 1'b0, 4'b0100};
    tbl[11] = '{4'b1001, 1'b0, 1'b0, 4'b1000};
    tbl[12] = '{4'b0001, 1'b0, 1'b0, 4'b0001};
    tbl[13] = '{4'b1111, 1'b1, 1'b0, 4'b0000};
    tbl[14] = '{4'b1111, 1'b0, 1'b0, 4'b0001};
    tbl[15] = '{4'b1111, 1'b0, 1'b0, 4'b0010};
    tbl[16] = '{4'b1111, 1'b0, 1'b0, 4'b0100};
    tbl[17] = '{4'b1111, 1'b0, 1'b0, 4'b1000};
    tbl[18] = '{4'b1111, 1'b0, 1'b0, 4'b0001};
    tbl[19] = '{4'b0001, 1'b0, 1'b0, 4'b0001};
    tbl[20] = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[21] = '{4'b0100, 1'b0, 1'b1, 4'b0000};
    tbl[22] = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[23] = '{4'b1010, 1'b0, 1'b0, 4'b0010};
    tbl[24] = '{4'b1010, 1'b0, 1'b0, 4'b1000};
    tbl[25] = '{4'b1000, 1'b0, 1'b0, 4'b1000};

    reset   = 1'b1;
    squash  = 1'b0;
    fu_done = '0;
    fu_take_branch = '0;
    fu_v = '0;
    fu_rob_tag = '0;
    fu_branch_loc = '0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 26; i++) step(tbl[i].done, tbl[i].sq, tbl[i].rst, tbl[i].ack);

    // Random traffic against the model; squash first so the model pointer starts aligned.
    m_ptr = 0;
    step(4'b1111, 1'b1, 1'b0, 4'b0000);
    for (int n = 0; n < 60; n++) begin
      for (int unsigned i = 0; i < NFU; i++) begin
        d_v[i]   = $urandom;
        d_tag[i] = TW'($urandom);
        d_tb[i]  = 1'($urandom);
        d_bl[i]  = $urandom;
      end
      rd = NFU'($urandom);
      rs = ($urandom_range(0, 7) == 0);
      ra = model_ack(rd, rs, 1'b0);
      if (rs) m_ptr = 0;
      else if (ra != '0) m_ptr = (onehot_idx(ra) + 1) % NFU;
      step(rd, rs, 1'b0, ra);
    end
    step(4'b0000, 1'b0, 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
